// File: rtl/mem_arb_if.sv
// mem_arb_if -- bundles the fetch port, the data port and the single-port RAM
// port of the memory arbiter.
//
// Parameters: AW word-address width, DW data width.
// Modports:
//   slave  : arbiter side (takes requests and RAM read data, drives grants,
//            responses and the RAM command).
//   master : environment side (requesters plus RAM model), the mirror image.
// Signals:
//   i_req/i_addr -> i_gnt, i_valid, i_rdata           fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_valid, d_rdata  data port
//   m_en/m_we/m_addr/m_wdata -> RAM, m_rdata <- RAM     RAM port
interface mem_arb_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_valid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb -- arbitrates a fetch port and a data port onto one single-port
// synchronous RAM (read data returns one cycle after m_en).
//
// Ports:
//   clock : rising-edge clock for all state
//   reset : asynchronous, active-low reset
//   bus   : mem_arb_if.slave (fetch port, data port, RAM port)
//
// Grants are combinational from the current requests and the registered
// arbitration state; at most one RAM access is issued per cycle. A 3-state
// FSM remembers which port owns the read returning in the next cycle.
//
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution.
// Without it, data wins conflicts unless the fetch port has waited MAX_WAIT
// cycles, in which case fetch wins.
module mem_arb #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  mem_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND_I = 2'd1,
    PEND_D = 2'd2
  } state_t;

  state_t        state_r;
  logic          i_gnt_s;
  logic          d_gnt_s;
  logic          conflict_s;
  logic          pick_fetch_s;
  logic [AW-1:0] m_addr_s;
  logic [DW-1:0] m_wdata_s;

  assign conflict_s = bus.i_req & bus.d_req;

`ifdef MEM_ARB_RR_EN
  // last_winner_r: 1'b0 = fetch, 1'b1 = data. Before the first conflict
  // after reset there is no previous conflict, so fetch goes first.
  localparam logic LW_FETCH = 1'b0;
  localparam logic LW_DATA  = 1'b1;

  logic last_winner_r;
  logic conflict_seen_r;

  assign pick_fetch_s = ~conflict_seen_r | (last_winner_r == LW_DATA);

  // Round-robin history, updated only on conflict cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_winner_r   <= LW_FETCH;
      conflict_seen_r <= 1'b0;
    end else if (conflict_s) begin
      last_winner_r   <= i_gnt_s ? LW_FETCH : LW_DATA;
      conflict_seen_r <= 1'b1;
    end else begin
      last_winner_r   <= last_winner_r;
      conflict_seen_r <= conflict_seen_r;
    end
  end
`else
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_WAIT_C = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt_r;

  assign pick_fetch_s = (wait_cnt_r == MAX_WAIT_C);

  // Fetch starvation counter: counts refused fetch cycles, saturating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (i_gnt_s || !bus.i_req) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (wait_cnt_r != MAX_WAIT_C) begin
      wait_cnt_r <= wait_cnt_r + WCW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`endif

  // Grant selection; nothing is granted while reset is held low.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!reset) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (conflict_s) begin
      if (pick_fetch_s) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (bus.i_req) begin
      i_gnt_s = 1'b1;
    end else if (bus.d_req) begin
      d_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // RAM command mux: granted port's address/data, zeros when idle.
  always_comb begin
    m_addr_s  = {AW{1'b0}};
    m_wdata_s = {DW{1'b0}};
    if (i_gnt_s) begin
      m_addr_s = bus.i_addr;
    end else if (d_gnt_s) begin
      m_addr_s  = bus.d_addr;
      m_wdata_s = bus.d_wdata;
    end else begin
      m_addr_s  = {AW{1'b0}};
      m_wdata_s = {DW{1'b0}};
    end
  end

  // Pending-read FSM: the state names the owner of next cycle's m_rdata.
  // A write grant or no grant leaves nothing pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE, PEND_I, PEND_D: begin
          if (i_gnt_s) begin
            state_r <= PEND_I;
          end else if (d_gnt_s && !bus.d_we) begin
            state_r <= PEND_D;
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.i_gnt   = i_gnt_s;
  assign bus.d_gnt   = d_gnt_s;
  assign bus.m_en    = i_gnt_s | d_gnt_s;
  assign bus.m_we    = d_gnt_s & bus.d_we;
  assign bus.m_addr  = m_addr_s;
  assign bus.m_wdata = m_wdata_s;

  assign bus.i_valid = (state_r == PEND_I);
  assign bus.d_valid = (state_r == PEND_D);
  assign bus.i_rdata = (state_r == PEND_I) ? bus.m_rdata : {DW{1'b0}};
  assign bus.d_rdata = (state_r == PEND_D) ? bus.m_rdata : {DW{1'b0}};

endmodule
